// File: rtl/dmem_load_store_unit_if.sv
// Bundled request/response and data-memory signals of the load/store unit.
// The unit sits on the slave modport; the execute stage and memory model use master.
interface dmem_load_store_unit_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_is_store;
    logic [2:0]            req_funct3;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [4:0]            req_rd;

    logic                  resp_valid;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic [4:0]            resp_rd;
    logic                  resp_err;
    logic [1:0]            resp_err_code;
    logic [ADDR_WIDTH-1:0] resp_badaddr;
    logic                  busy;

    logic [ADDR_WIDTH-1:0] dmem_addr;
    logic [DATA_WIDTH-1:0] dmem_write_data;
    logic                  dmem_read;
    logic                  dmem_write;
    logic [3:0]            dmem_byte_enable;
    logic [DATA_WIDTH-1:0] dmem_read_data;
    logic                  dmem_ready;

    modport slave (
        input  req_valid, req_is_store, req_funct3, req_addr, req_wdata, req_rd,
        input  dmem_read_data, dmem_ready,
        output req_ready, resp_valid, resp_rdata, resp_rd, resp_err, resp_err_code,
        output resp_badaddr, busy,
        output dmem_addr, dmem_write_data, dmem_read, dmem_write, dmem_byte_enable
    );

    modport master (
        output req_valid, req_is_store, req_funct3, req_addr, req_wdata, req_rd,
        output dmem_read_data, dmem_ready,
        input  req_ready, resp_valid, resp_rdata, resp_rd, resp_err, resp_err_code,
        input  resp_badaddr, busy,
        input  dmem_addr, dmem_write_data, dmem_read, dmem_write, dmem_byte_enable
    );
endinterface

// File: rtl/dmem_load_store_unit.sv
// RV32 load/store unit: validates funct3/alignment, issues a word-aligned dmem
// request with byte enables, waits for dmem_ready under a timeout, returns extended data.
module dmem_load_store_unit #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input logic                   clk,
    input logic                   rst_n,
    dmem_load_store_unit_if.slave bus
);
    localparam int              CW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                state, state_nxt;

    logic                  op_store;
    logic [2:0]            op_f3;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [4:0]            rd_r;
    logic [3:0]            be_r;
    logic [DATA_WIDTH-1:0] wdata_r;
    logic [DATA_WIDTH-1:0] rdata_r;
    logic                  err_r;
    logic [1:0]            code_r;
    logic [CW-1:0]         cnt;

    logic                  accept;
    logic                  req_legal;
    logic                  req_misaligned;
    logic                  req_err;
    logic [1:0]            req_code;
    logic [1:0]            off;
    logic [3:0]            req_be;
    logic [DATA_WIDTH-1:0] wmask;
    logic [DATA_WIDTH-1:0] req_wlane;
    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] load_ext;

    assign accept = bus.req_valid && (state != ACCESS);

    always_comb begin
        off            = bus.req_addr[1:0];
        req_misaligned = 1'b0;
        req_be         = '0;
        wmask          = '0;
        case (bus.req_funct3)
            3'b000, 3'b001, 3'b010: req_legal = 1'b1;
            3'b100, 3'b101:         req_legal = !bus.req_is_store;
            default:                req_legal = 1'b0;
        endcase
        case (bus.req_funct3[1:0])
            2'b00: begin
                req_be = 4'b0001 << off;
                wmask  = DATA_WIDTH'(8'hFF);
            end
            2'b01: begin
                req_misaligned = off[0];
                req_be         = 4'b0011 << off;
                wmask          = DATA_WIDTH'(16'hFFFF);
            end
            default: begin
                req_misaligned = |off;
                req_be         = 4'b1111;
                wmask          = '1;
            end
        endcase
        req_wlane = (bus.req_wdata & wmask) << {off, 3'b000};
        req_err   = !req_legal || req_misaligned;
        if (!req_legal)
            req_code = 2'd3;
        else if (bus.req_is_store)
            req_code = 2'd1;
        else
            req_code = 2'd0;
    end

    always_comb begin
        shifted = bus.dmem_read_data >> {addr_r[1:0], 3'b000};
        case (op_f3)
            3'b000:  load_ext = {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
            3'b001:  load_ext = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
            3'b100:  load_ext = {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]};
            3'b101:  load_ext = {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
            default: load_ext = shifted;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // dmem_ready seen in RESP is the stale tail of the previous access, so only ACCESS looks at it
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, RESP: begin
                if (accept)
                    state_nxt = req_err ? RESP : ACCESS;
                else
                    state_nxt = IDLE;
            end
            ACCESS: begin
                if (bus.dmem_ready || cnt == CNT_LAST)
                    state_nxt = RESP;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_store <= 1'b0;
            op_f3    <= '0;
            addr_r   <= '0;
            rd_r     <= '0;
            be_r     <= '0;
            wdata_r  <= '0;
            rdata_r  <= '0;
            err_r    <= 1'b0;
            code_r   <= '0;
            cnt      <= '0;
        end else if (accept) begin
            op_store <= bus.req_is_store;
            op_f3    <= bus.req_funct3;
            addr_r   <= bus.req_addr;
            rd_r     <= bus.req_rd;
            be_r     <= req_be;
            wdata_r  <= req_wlane;
            rdata_r  <= '0;
            err_r    <= req_err;
            code_r   <= req_code;
            cnt      <= '0;
        end else if (state == ACCESS) begin
            cnt <= cnt + 1'b1;
            if (bus.dmem_ready) begin
                rdata_r <= op_store ? '0 : load_ext;
            end else if (cnt == CNT_LAST) begin
                err_r  <= 1'b1;
                code_r <= 2'd2;
            end
        end
    end

    always_comb begin
        bus.req_ready        = (state != ACCESS);
        bus.busy             = (state != IDLE);
        bus.dmem_read        = (state == ACCESS) && !op_store;
        bus.dmem_write       = (state == ACCESS) && op_store;
        bus.dmem_addr        = {addr_r[ADDR_WIDTH-1:2], 2'b00};
        bus.dmem_byte_enable = be_r;
        bus.dmem_write_data  = wdata_r;
        bus.resp_valid       = (state == RESP);
        bus.resp_rdata       = rdata_r;
        bus.resp_rd          = rd_r;
        bus.resp_err         = err_r;
        bus.resp_err_code    = code_r;
        bus.resp_badaddr     = err_r ? addr_r : '0;
    end

    a_rw_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.dmem_read && bus.dmem_write));
    a_cnt_bound: assert property (@(posedge clk) disable iff (!rst_n)
        (state == ACCESS) |-> (cnt <= CNT_LAST));

endmodule
